// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
// Purpose : definitions common to the UART receiver, its receive FIFO and
//           the existing transmitter.
// Contents: UART_DATA_W, UART_CLKS_PER_BIT, receiver state constants/enum.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  // 100 MHz system clock / 115200 baud
  localparam int UART_CLKS_PER_BIT = 868;

  // Fixed encodings so the state value is stable across tool flows.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    BREAK = ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous circular FIFO for received bytes
// Purpose : DEPTH-entry receive buffer, used by uart_rx when UART_RX_FIFO_EN
//           is defined.
// Ports   : clk, rst (sync, active-high)
//           i_push/i_data  write side; dropped when full unless popped same cycle
//           i_pop          read side; ignored when empty
//           o_data         head entry (0 while empty)
//           o_full/o_empty status
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [UART_DATA_W-1:0] i_data,
  input  logic                   i_pop,
  output logic [UART_DATA_W-1:0] o_data,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  logic                   w_do_push;
  logic                   w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready byte output
// Purpose : samples an idle-high serial line mid-bit, LSB first, and
//           presents received bytes on a valid/ready stream.
// Config  : define UART_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO;
//           otherwise a single holding register buffers one byte.
// Ports   : clk        system clock
//           rst        synchronous reset, active-high
//           rxd        asynchronous serial input, idle high
//           rx_data    received byte, valid while rx_valid=1
//           rx_valid   byte available
//           rx_ready   consumer accepts (transfer on rx_valid && rx_ready)
//           frame_err  one-cycle pulse, stop bit sampled low
//           overrun    one-cycle pulse, completed byte dropped (buffer full)
//           busy       receiver not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  logic                   r_sync1;
  logic                   r_rxs;
  logic                   r_rxs_d;
  uart_state_e            r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_bit_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic                   w_fall;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  assign w_fall = r_rxs_d & ~r_rxs;
  assign w_push = (r_state == STOP) && (r_cnt == BIT_LAST) && r_rxs;
  assign w_pop  = rx_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= START;
        end
        START: begin
          if (r_cnt == HALF_LAST) begin
            // Line back high at the start-bit midpoint: treat as a glitch.
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rxs ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_rxs;
            if (r_bit_idx == 3'd7) r_state   <= STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            if (r_rxs) begin
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        BREAK: begin
          // Wait for the line to recover so a held-low line cannot retrigger.
          r_cnt <= '0;
          if (r_rxs) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_overrun <= 1'b0;
    else     r_overrun <= w_push & w_full & ~w_pop;
  end

`ifdef UART_RX_FIFO_EN
  logic w_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rx_valid = ~w_empty;
`else
  logic [UART_DATA_W-1:0] r_data;
  logic                   r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_push && (!r_valid || w_pop)) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign w_full   = r_valid;
  assign rx_valid = r_valid;
  assign rx_data  = r_data;
`endif

  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         n_pops = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         n_valid = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted byte must match the oldest expected one.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (rx_valid)  n_valid++;
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (rx_valid && rx_ready) begin
        n_pops++;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_byte: observed 0x%0h expected none", rx_data);
        end
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          checks++;
          assert (rx_data === mon_exp) else begin
            errors++;
            $error("FAIL rx_data: observed 0x%0h expected 0x%0h", rx_data, mon_exp);
          end
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (stop_low_bits == 0) drive_bit(1'b1);
    else for (int i = 0; i < stop_low_bits; i++) drive_bit(1'b0);
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  int         v0, p0, f0, o0, n;
  logic       stable;
  logic [7:0] b;

  initial begin
    rst = 1'b1; rxd = 1'b1; rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0; rx_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte with consumer always ready
    v0 = n_valid;
    send_good(8'h55);
    wait_drain("single_55_drain", 64);
    repeat (4) @(negedge clk);
    check("single_valid_cycles", n_valid - v0, 1);
    check("single_no_ferr", n_ferr, 0);
    check("single_busy_idle", busy, 0);

    // Short low glitch on idle line
    p0 = n_pops;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_byte", n_pops - p0, 0);
    check("glitch_no_ferr", n_ferr, 0);
    check("glitch_busy_idle", busy, 0);

    // Stop bit held low for three bit times
    p0 = n_pops;
    send_frame(8'hA3, 3);
    check("frame_busy_while_low", busy, 1);
    check("frame_err_pulses", n_ferr, 1);
    check("frame_no_byte", n_pops - p0, 0);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    check("frame_busy_released", busy, 0);
    send_good(8'h3C);
    wait_drain("frame_next_3c_drain", 64);

    // Back-to-back bytes with consumer stalled
    rx_ready = 1'b0;
    o0 = n_ovr;
`ifdef UART_RX_FIFO_EN
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(i[7:0]);
      send_frame(i[7:0], 0);
      if (i == 15) check("fifo_no_early_overrun", n_ovr - o0, 0);
    end
    repeat (4) @(negedge clk);
    check("fifo_overrun_pulses", n_ovr - o0, 1);
    check("fifo_head_data", rx_data, 8'h00);
    rx_ready = 1'b1;
    wait_drain("fifo_drain", 64);
`else
    exp_q.push_back(8'h11);
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    repeat (4) @(negedge clk);
    check("hold_overrun_pulses", n_ovr - o0, 1);
    check("hold_valid", rx_valid, 1);
    check("hold_data_kept", rx_data, 8'h11);
    rx_ready = 1'b1;
    wait_drain("hold_drain", 64);
`endif

    // Backpressure: byte must be held stable until accepted
    rx_ready = 1'b0;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 0);
    n = 0;
    while (!rx_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", rx_valid, 1);
    stable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!(rx_valid === 1'b1 && rx_data === 8'h7E)) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("bp_valid_falls", rx_valid, 0);
    check("bp_popped", exp_q.size(), 0);
    rx_ready = 1'b1;

    // Reset during data bit 4 of 0xF0
    p0 = n_pops;
    b = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rxd = b[4];
    repeat (CPB / 2) @(negedge clk);
    check("midframe_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("midrst_no_byte", n_pops - p0, 0);
    check("midrst_busy_idle", busy, 0);
    send_good(8'h9A);
    wait_drain("midrst_next_9a_drain", 64);
    check("total_frame_err_pulses", n_ferr, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
